// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: maps MIDI note-on/off events onto NCH voice channels,
// retriggering held notes, filling free channels lowest-first and stealing the oldest voice.
module midi_voice_allocator #(
  parameter int unsigned NCH  = 8,
  parameter int unsigned AGEW = 16
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [6:0]         iNoteNumber,
  input  logic               iNoteOn,
  input  logic               iNoteOff,
  output logic [NCH*7-1:0]   oChNoteNumber,
  output logic [NCH-1:0]     oChActive,
  output logic [NCH-1:0]     oChStart,
  output logic [NCH-1:0]     oChRelease,
  output logic               oSteal,
  output logic [4:0]         oActiveCount
);

  localparam int unsigned NOTEW = 7;
  localparam int unsigned CNTW  = 5;
  localparam logic [AGEW-1:0] AGE_MAX = '1;

  // Input event stage; an event held here is in flight and is dropped by reset.
  logic             on_q, on_d;
  logic             off_q, off_d;
  logic [NOTEW-1:0] num_q, num_d;

  logic [NCH-1:0][NOTEW-1:0] note_q, note_d;
  logic [NCH-1:0][AGEW-1:0]  age_q, age_d;
  logic [NCH-1:0]            active_q, active_d;
  logic [NCH-1:0]            start_q, start_d;
  logic [NCH-1:0]            release_q, release_d;
  logic                      steal_q, steal_d;
  logic [CNTW-1:0]           count_q, count_d;

  logic [NCH-1:0] hit;
  logic [NCH-1:0] free_oh;
  logic [NCH-1:0] old_oh;
  logic [NCH-1:0] avail;
  logic           free_found;
  logic           off_en;
  logic [AGEW-1:0] old_age;

  always_comb begin
    on_d      = iNoteOn;
    off_d     = iNoteOff;
    num_d     = iNoteNumber;
    note_d    = note_q;
    active_d  = active_q;
    age_d     = age_q;
    start_d   = '0;
    release_d = '0;
    steal_d   = 1'b0;
    count_d   = '0;
    hit       = '0;
    free_oh   = '0;
    old_oh    = '0;
    avail     = '0;
    free_found = 1'b0;
    old_age   = '0;

    for (int unsigned k = 0; k < NCH; k++) begin
      hit[k] = active_q[k] && (note_q[k] == num_q);
    end

    // With a single note bus, a simultaneous on/off always names the same note: on wins.
    off_en = off_q && !on_q;
    if (off_en && (|hit)) begin
      active_d  = active_q & ~hit;
      release_d = hit;
    end

    // Channels free after the off has been applied are candidates for allocation.
    avail = ~active_d;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (avail[k] && !free_found) begin
        free_oh[k] = 1'b1;
        free_found = 1'b1;
      end
    end

    // Oldest voice; strict compare keeps the lowest index on a tie.
    old_oh[0] = 1'b1;
    old_age   = age_q[0];
    for (int unsigned k = 1; k < NCH; k++) begin
      if (age_q[k] > old_age) begin
        old_oh  = '0;
        old_oh[k] = 1'b1;
        old_age = age_q[k];
      end
    end

    if (on_q) begin
      if (|hit) begin
        start_d = hit;
      end else if (free_found) begin
        start_d = free_oh;
      end else begin
        start_d   = old_oh;
        release_d = old_oh;
        steal_d   = 1'b1;
      end
      for (int unsigned k = 0; k < NCH; k++) begin
        if (start_d[k]) begin
          note_d[k]   = num_q;
          active_d[k] = 1'b1;
        end
      end
    end

    for (int unsigned k = 0; k < NCH; k++) begin
      if (!active_d[k] || start_d[k]) begin
        age_d[k] = '0;
      end else if (age_q[k] != AGE_MAX) begin
        age_d[k] = age_q[k] + AGEW'(1);
      end
      count_d = count_d + CNTW'(active_d[k]);
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      on_q      <= 1'b0;
      off_q     <= 1'b0;
      num_q     <= '0;
      note_q    <= '0;
      age_q     <= '0;
      active_q  <= '0;
      start_q   <= '0;
      release_q <= '0;
      steal_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      on_q      <= on_d;
      off_q     <= off_d;
      num_q     <= num_d;
      note_q    <= note_d;
      age_q     <= age_d;
      active_q  <= active_d;
      start_q   <= start_d;
      release_q <= release_d;
      steal_q   <= steal_d;
      count_q   <= count_d;
    end
  end

  assign oChNoteNumber = note_q;
  assign oChActive     = active_q;
  assign oChStart      = start_q;
  assign oChRelease    = release_q;
  assign oSteal        = steal_q;
  assign oActiveCount  = count_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator (NCH=8): allocation, retrigger, release,
// stealing by age, ignored note-off and asynchronous reset with an event in flight.
module tb_midi_voice_allocator;

  localparam int unsigned NCH = 8;

  logic             iCLK = 1'b0;
  logic             iRST;
  logic [6:0]       iNoteNumber;
  logic             iNoteOn;
  logic             iNoteOff;
  logic [NCH*7-1:0] oChNoteNumber;
  logic [NCH-1:0]   oChActive;
  logic [NCH-1:0]   oChStart;
  logic [NCH-1:0]   oChRelease;
  logic             oSteal;
  logic [4:0]       oActiveCount;

  int total = 0;
  int bad   = 0;

  midi_voice_allocator #(.NCH(NCH), .AGEW(16)) dut (
    .iCLK          (iCLK),
    .iRST          (iRST),
    .iNoteNumber   (iNoteNumber),
    .iNoteOn       (iNoteOn),
    .iNoteOff      (iNoteOff),
    .oChNoteNumber (oChNoteNumber),
    .oChActive     (oChActive),
    .oChStart      (oChStart),
    .oChRelease    (oChRelease),
    .oSteal        (oSteal),
    .oActiveCount  (oActiveCount)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Present one event for exactly one sampling edge.
  task automatic drive(input logic on, input logic off, input logic [6:0] n);
    iNoteOn     = on;
    iNoteOff    = off;
    iNoteNumber = n;
    tick();
    iNoteOn  = 1'b0;
    iNoteOff = 1'b0;
  endtask

  function automatic logic [6:0] ch_note(input int k);
    logic [NCH*7-1:0] bus;
    bus = oChNoteNumber;
    return bus[k*7 +: 7];
  endfunction

  initial begin
    iRST = 1'b1;
    iNoteOn = 1'b0;
    iNoteOff = 1'b0;
    iNoteNumber = '0;
    repeat (3) tick();

    check("rst_active", 64'(oChActive), 64'h0);
    check("rst_notes",  64'(oChNoteNumber), 64'h0);
    check("rst_start",  64'(oChStart), 64'h0);
    check("rst_rel",    64'(oChRelease), 64'h0);
    check("rst_steal",  64'(oSteal), 64'h0);
    check("rst_count",  64'(oActiveCount), 64'h0);

    iRST = 1'b0;
    tick();

    // Back-to-back note-ons 60, 62, 64 fill channels 0..2.
    drive(1'b1, 1'b0, 7'd60);
    drive(1'b1, 1'b0, 7'd62);
    check("seq_start0", 64'(oChStart), 64'h01);
    drive(1'b1, 1'b0, 7'd64);
    check("seq_start1", 64'(oChStart), 64'h02);
    tick();
    check("seq_start2", 64'(oChStart), 64'h04);
    check("seq_active", 64'(oChActive), 64'h07);
    check("seq_count",  64'(oActiveCount), 64'd3);
    check("seq_notes",  64'(oChNoteNumber[20:0]), 64'({7'd64, 7'd62, 7'd60}));
    tick();
    check("seq_start_clr", 64'(oChStart), 64'h0);

    // Retrigger of a held note.
    drive(1'b1, 1'b0, 7'd60);
    tick();
    check("retrig_start", 64'(oChStart), 64'h01);
    check("retrig_rel",   64'(oChRelease), 64'h0);
    check("retrig_steal", 64'(oSteal), 64'h0);
    check("retrig_count", 64'(oActiveCount), 64'd3);
    tick();
    check("retrig_clr", 64'(oChStart), 64'h0);

    // Note-off for a note nobody holds.
    drive(1'b0, 1'b1, 7'd99);
    tick();
    check("off99_start",  64'(oChStart), 64'h0);
    check("off99_rel",    64'(oChRelease), 64'h0);
    check("off99_active", 64'(oChActive), 64'h07);

    // Release of note 62 keeps the stored note.
    drive(1'b0, 1'b1, 7'd62);
    tick();
    check("off62_rel",    64'(oChRelease), 64'h02);
    check("off62_active", 64'(oChActive), 64'h05);
    check("off62_count",  64'(oActiveCount), 64'd2);
    check("off62_note",   64'(ch_note(1)), 64'd62);
    tick();
    check("off62_rel_clr", 64'(oChRelease), 64'h0);

    // Simultaneous on/off of the same note acts as note-on only.
    drive(1'b1, 1'b1, 7'd64);
    tick();
    check("onoff_start",  64'(oChStart), 64'h04);
    check("onoff_rel",    64'(oChRelease), 64'h0);
    check("onoff_active", 64'(oChActive), 64'h05);

    // Fresh start: notes 40..47 ten cycles apart, then steal the oldest.
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 7'(40 + i));
      repeat (9) tick();
    end
    check("full_active", 64'(oChActive), 64'hFF);
    check("full_count",  64'(oActiveCount), 64'd8);
    drive(1'b1, 1'b0, 7'd50);
    tick();
    check("steal0_rel",   64'(oChRelease), 64'h01);
    check("steal0_start", 64'(oChStart), 64'h01);
    check("steal0_steal", 64'(oSteal), 64'h1);
    check("steal0_note",  64'(ch_note(0)), 64'd50);
    check("steal0_count", 64'(oActiveCount), 64'd8);
    tick();
    check("steal0_clr", 64'(oSteal), 64'h0);

    // Free channel 3 with note-off 43, then note-on 70 reuses it without stealing.
    drive(1'b0, 1'b1, 7'd43);
    drive(1'b1, 1'b0, 7'd70);
    check("re3_rel",    64'(oChRelease), 64'h08);
    check("re3_count7", 64'(oActiveCount), 64'd7);
    tick();
    check("re3_start", 64'(oChStart), 64'h08);
    check("re3_steal", 64'(oSteal), 64'h0);
    check("re3_count", 64'(oActiveCount), 64'd8);
    check("re3_note",  64'(ch_note(3)), 64'd70);

    // Oldest voice is now channel 1.
    drive(1'b1, 1'b0, 7'd51);
    tick();
    check("steal1_rel",   64'(oChRelease), 64'h02);
    check("steal1_start", 64'(oChStart), 64'h02);
    check("steal1_steal", 64'(oSteal), 64'h1);
    check("steal1_note",  64'(ch_note(1)), 64'd51);

    // Five active voices, then asynchronous reset with an event in flight.
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 7'(1 + i));
    tick();
    check("pre_rst_count", 64'(oActiveCount), 64'd5);
    iNoteOn = 1'b1;
    iNoteNumber = 7'd9;
    @(posedge iCLK);
    #2;
    iNoteOn = 1'b0;
    iRST = 1'b1;
    #1;
    check("async_active", 64'(oChActive), 64'h0);
    check("async_count",  64'(oActiveCount), 64'd0);
    check("async_notes",  64'(oChNoteNumber), 64'h0);
    repeat (2) tick();
    iRST = 1'b0;
    repeat (2) tick();
    check("inflight_drop", 64'(oChActive), 64'h0);
    drive(1'b1, 1'b0, 7'd60);
    tick();
    check("post_rst_start",  64'(oChStart), 64'h01);
    check("post_rst_active", 64'(oChActive), 64'h01);
    check("post_rst_note",   64'(ch_note(0)), 64'd60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
